// File: rtl/ex_flag_branch_unit.sv
// ex_flag_branch_unit: commits ALU flags, resolves branches on the committed flags, registers EX/MEM and squashes the wrong-path slot.
module ex_flag_branch_unit #(
  parameter int DW = 16,
  parameter logic [2:0] RST_FLAGS = 3'b000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [3:0]    ex_alu_ctrl,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_z,
  input  logic          ex_n,
  input  logic          ex_v,
  input  logic          ex_is_branch,
  input  logic [2:0]    ex_cond,
  input  logic [DW-1:0] ex_target,
  input  logic          stall,
  input  logic          flush,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_v,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target
);
  typedef enum logic {NORMAL, SQUASH} state_t;
  state_t state;
  logic live, alu_live, full_op, z_op, cond_ok, take;
  always_comb begin
    live = ex_valid && !flush && !stall && state == NORMAL;
    alu_live = live && !ex_is_branch;
    full_op = ex_alu_ctrl == 4'b0000 || ex_alu_ctrl == 4'b0001;
    z_op = ex_alu_ctrl inside {4'b0100, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
    cond_ok = 1'b0;
    case (ex_cond)
      3'd0: cond_ok = !flag_z;
      3'd1: cond_ok = flag_z;
      3'd2: cond_ok = !flag_z && !flag_n;
      3'd3: cond_ok = flag_n;
      3'd4: cond_ok = flag_z || !flag_n;
      3'd5: cond_ok = flag_z || flag_n;
      3'd6: cond_ok = flag_v;
      default: cond_ok = 1'b1;
    endcase
    take = live && ex_is_branch && cond_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {flag_z, flag_n, flag_v} <= RST_FLAGS;
      mem_valid <= 1'b0;
      mem_result <= '0;
      branch_taken <= 1'b0;
      branch_target <= '0;
      state <= NORMAL;
    end else begin
      if (alu_live && full_op) {flag_z, flag_n, flag_v} <= {ex_z, ex_n, ex_v};
      else if (alu_live && z_op) flag_z <= ex_z;
      // flush outranks stall, so a flushed slot never lingers as valid
      mem_valid <= flush ? 1'b0 : stall ? mem_valid : live;
      if (live) mem_result <= ex_result;
      branch_taken <= take;
      if (take) branch_target <= ex_target;
      state <= flush ? NORMAL : stall ? state : take ? SQUASH : NORMAL;
    end
  end
endmodule

// File: tb/tb_ex_flag_branch_unit.sv
// tb_ex_flag_branch_unit: directed scenarios plus random traffic checked against a behavioural model.
module tb_ex_flag_branch_unit;
  logic clk = 0, rst = 0;
  logic ex_valid = 0, ex_z = 0, ex_n = 0, ex_v = 0, ex_is_branch = 0, stall = 0, flush = 0;
  logic [3:0] ex_alu_ctrl = 0;
  logic [15:0] ex_result = 0, ex_target = 0;
  logic [2:0] ex_cond = 0;
  logic flag_z, flag_n, flag_v, mem_valid, branch_taken;
  logic [15:0] mem_result, branch_target;
  int checks = 0, errors = 0;
  bit [2:0] m_flags;
  bit m_mv, m_bt, m_squash;
  bit [15:0] m_mr, m_tgt;

  ex_flag_branch_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_result(ex_result),
    .ex_z(ex_z), .ex_n(ex_n), .ex_v(ex_v), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
    .ex_target(ex_target), .stall(stall), .flush(flush), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .mem_valid(mem_valid), .mem_result(mem_result), .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_met(input bit [2:0] c, input bit [2:0] f);
    bit z, n, v;
    bit [7:0] tab;
    {z, n, v} = f;
    tab = {1'b1, v, z | n, z | ~n, n, ~z & ~n, z, ~z};
    return tab[c];
  endfunction

  task automatic model_step();
    bit live, taken;
    if (rst) begin
      m_flags = 3'b000; m_mv = 0; m_mr = 0; m_bt = 0; m_tgt = 0; m_squash = 0;
      return;
    end
    live = ex_valid && !flush && !stall && !m_squash;
    taken = live && ex_is_branch && cond_met(ex_cond, m_flags);
    if (live && !ex_is_branch) begin
      if (ex_alu_ctrl <= 4'd1) m_flags = {ex_z, ex_n, ex_v};
      else if (ex_alu_ctrl inside {4, 8, 12, 14, 15}) m_flags[2] = ex_z;
    end
    if (flush) m_mv = 0;
    else if (!stall) m_mv = live;
    if (live) m_mr = ex_result;
    m_bt = taken;
    if (taken) m_tgt = ex_target;
    m_squash = flush ? 0 : stall ? m_squash : taken;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("flags", {flag_z, flag_n, flag_v}, m_flags);
    chk("mem_valid", mem_valid, m_mv);
    chk("mem_result", mem_result, m_mr);
    chk("branch_taken", branch_taken, m_bt);
    chk("branch_target", branch_target, m_tgt);
    @(negedge clk);
    rst = 0; stall = 0; flush = 0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [15:0] r, input logic z, n, v);
    ex_valid = 1; ex_is_branch = 0; ex_alu_ctrl = op; ex_result = r; {ex_z, ex_n, ex_v} = {z, n, v};
    cycle();
  endtask

  task automatic br(input logic [2:0] c, input logic [15:0] t);
    ex_valid = 1; ex_is_branch = 1; ex_cond = c; ex_target = t;
    cycle();
  endtask

  task automatic idle();
    ex_valid = 0; ex_is_branch = 0;
    cycle();
  endtask

  initial begin
    @(negedge clk);
    rst = 1; ex_valid = 1; ex_alu_ctrl = 0; ex_z = 1; ex_n = 1; ex_v = 1;
    cycle();
    chk("rst_flags", {flag_z, flag_n, flag_v}, 3'b000);
    chk("rst_mv", mem_valid, 0);
    chk("rst_bt", branch_taken, 0);
    // SUB 5-5 then EQ
    alu(4'b0001, 16'h0000, 1, 0, 0);
    chk("t1_flags", {flag_z, flag_n, flag_v}, 3'b100);
    br(3'd1, 16'h1234);
    chk("t1_taken", branch_taken, 1);
    chk("t1_target", branch_target, 16'h1234);
    // wrong-path ADD squashed, next one accepted
    alu(4'b0000, 16'h0042, 0, 1, 0);
    chk("t3_squash_mv", mem_valid, 0);
    chk("t3_squash_flags", {flag_z, flag_n, flag_v}, 3'b100);
    alu(4'b0000, 16'h0043, 0, 1, 0);
    chk("t3_accept_mv", mem_valid, 1);
    // ADD overflow then XOR keeps N,V; OV taken
    alu(4'b0000, 16'h8000, 0, 1, 1);
    alu(4'b1000, 16'h0001, 0, 0, 0);
    chk("t2_flags", {flag_z, flag_n, flag_v}, 3'b011);
    br(3'd6, 16'hbeef);
    chk("t2_ov_taken", branch_taken, 1);
    idle();
    // stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      alu(4'b0000, 16'h0000, 1, 0, 0);
      chk("t4_no_pulse", branch_taken, 0);
    end
    alu(4'b0000, 16'h0000, 1, 0, 0);
    chk("t4_release", {flag_z, flag_n, flag_v}, 3'b100);
    // flush+stall on taken branch
    flush = 1; stall = 1;
    br(3'd7, 16'h5555);
    chk("t5_no_pulse", branch_taken, 0);
    chk("t5_mv", mem_valid, 0);
    br(3'd7, 16'h6666);
    chk("t5_normal", branch_taken, 1);
    idle();
    // reset mid-SQUASH
    alu(4'b0000, 16'hffff, 1, 1, 1);
    br(3'd7, 16'h7777);
    rst = 1;
    alu(4'b0000, 16'h0001, 0, 0, 0);
    chk("t6_rst_flags", {flag_z, flag_n, flag_v}, 3'b000);
    chk("t6_rst_bt", branch_taken, 0);
    alu(4'b0000, 16'h0002, 0, 1, 0);
    chk("t6_commit", {flag_z, flag_n, flag_v}, 3'b010);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [3:0] ops [8] = '{0, 1, 4, 8, 12, 14, 15, 0};
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      ex_valid = ($urandom_range(0, 5) != 0);
      ex_is_branch = ($urandom_range(0, 2) == 0);
      ex_alu_ctrl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      ex_result = 16'($urandom);
      {ex_z, ex_n, ex_v} = 3'($urandom);
      ex_cond = 3'($urandom);
      ex_target = 16'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
